// File: rtl/trend_pkg.sv
// Shared trend-select encoding and match rule for the window trend counter.
package trend_pkg;

    typedef logic [1:0] trend_mode_t;

    localparam trend_mode_t MODE_INC  = 2'b00;
    localparam trend_mode_t MODE_DEC  = 2'b01;
    localparam trend_mode_t MODE_EQ   = 2'b10;
    localparam trend_mode_t MODE_RSVD = 2'b11;

    // Decide whether one comparison outcome counts under the selected trend.
    // The magnitude compare is done by the caller so this stays width-free.
    function automatic logic trend_hit(
        input trend_mode_t mode,
        input logic        gt,
        input logic        lt,
        input logic        eq
    );
        logic hit;
        case (mode)
            MODE_INC: hit = gt;
            MODE_DEC: hit = lt;
            MODE_EQ:  hit = eq;
            default:  hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/sample_delay.sv
// Ring-buffer delay line: dout is the entry written DEPTH writes ago.
module sample_delay #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Next write slot, wrapping at DEPTH-1 so any depth works.
    always_comb begin
        ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    end

    // Write pointer advances once per accepted sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (wr_en) begin
            ptr_q <= ptr_d;
        end
    end

    // Storage array written at the current slot after its old value is read.
    // NOTE: the array carries no reset; stale contents are masked by the
    // owner's fill counter, so clearing it would only cost flops.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[ptr_q] <= din;
        end
    end

    // Read address equals write address: the slot about to be overwritten
    // holds the oldest sample.
    assign dout = mem_q[ptr_q];

endmodule

// File: rtl/window_trend_counter.sv
// Counts accepted samples that rise, fall or stay equal relative to the
// sample accepted WINDOW positions earlier.
module window_trend_counter
    import trend_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int WINDOW      = 3,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [WIDTH-1:0]       value,
    input  trend_mode_t            mode,
    output logic [COUNT_WIDTH-1:0] solution,
    output logic                   primed,
    output logic                   saturated
);

    localparam int FILL_W = $clog2(WINDOW + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WINDOW);

    logic [WIDTH-1:0]       old_value;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic [COUNT_WIDTH-1:0] solution_q, solution_d;
    logic                   primed_q, primed_d;
    logic                   saturated_q, saturated_d;
    logic                   run_phase;
    logic                   hit;

    sample_delay #(
        .WIDTH (WIDTH),
        .DEPTH (WINDOW)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .wr_en (enable & ~reset),
        .din   (value),
        .dout  (old_value)
    );

    // Next-state logic: fill the line first, then compare and count.
    // NOTE: every combinational output is given a default up front so no
    // path through the block can leave a latch behind.
    always_comb begin
        fill_d      = fill_q;
        solution_d  = solution_q;
        saturated_d = saturated_q;
        run_phase   = (fill_q == FILL_FULL);
        hit         = run_phase && trend_hit(mode,
                                             value > old_value,
                                             value < old_value,
                                             value == old_value);
        if (enable) begin
            if (!run_phase) begin
                fill_d = fill_q + 1'b1;
            end
            if (hit) begin
                if (&solution_q) begin
                    saturated_d = 1'b1;
                end else begin
                    solution_d = solution_q + 1'b1;
                end
            end
        end
        primed_d = (fill_d == FILL_FULL);
    end

    // State registers; reset wins over a sample presented in the same cycle.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_q      <= '0;
            solution_q  <= '0;
            primed_q    <= 1'b0;
            saturated_q <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            solution_q  <= solution_d;
            primed_q    <= primed_d;
            saturated_q <= saturated_d;
        end
    end

    assign solution  = solution_q;
    assign primed    = primed_q;
    assign saturated = saturated_q;

endmodule

// File: tb/tb_window_trend_counter.sv
// Directed bench for window_trend_counter: WINDOW=1, WINDOW=3 and a
// 3-bit saturating instance, checked against hand-computed results.
module tb_window_trend_counter;
    import trend_pkg::*;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] val;
    trend_mode_t mode;

    logic        s_rst;
    logic        s_en;
    logic [31:0] s_val;

    logic [31:0] w1_sol;
    logic        w1_primed, w1_sat;
    logic [31:0] w3_sol;
    logic        w3_primed, w3_sat;
    logic [2:0]  s_sol;
    logic        s_primed, s_sat;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] stream [10] = '{199, 200, 208, 210, 200, 207, 240, 269, 260, 263};

    window_trend_counter #(.WIDTH(32), .WINDOW(1), .COUNT_WIDTH(32)) u_w1 (
        .clk(clk), .reset(rst), .enable(en), .value(val), .mode(mode),
        .solution(w1_sol), .primed(w1_primed), .saturated(w1_sat)
    );

    window_trend_counter #(.WIDTH(32), .WINDOW(3), .COUNT_WIDTH(32)) u_w3 (
        .clk(clk), .reset(rst), .enable(en), .value(val), .mode(mode),
        .solution(w3_sol), .primed(w3_primed), .saturated(w3_sat)
    );

    window_trend_counter #(.WIDTH(32), .WINDOW(1), .COUNT_WIDTH(3)) u_sat (
        .clk(clk), .reset(s_rst), .enable(s_en), .value(s_val), .mode(MODE_INC),
        .solution(s_sol), .primed(s_primed), .saturated(s_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; outputs are read 1 time unit later.
    task automatic step(input logic e, input logic [31:0] v);
        en  = e;
        val = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_stream();
        for (int i = 0; i < 10; i++) step(1'b1, stream[i]);
        en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; val = '0; mode = MODE_INC;
        s_rst = 1'b1; s_en = 1'b0; s_val = '0;
        repeat (2) @(posedge clk);
        #1;
        s_rst = 1'b0;

        // Reset state
        check("rst_w1_sol", w1_sol, 0);
        check("rst_w1_primed", {31'd0, w1_primed}, 0);
        check("rst_w3_sol", w3_sol, 0);
        check("rst_w3_primed", {31'd0, w3_primed}, 0);
        check("rst_w3_sat", {31'd0, w3_sat}, 0);
        check("rst_s_sat", {31'd0, s_sat}, 0);

        // Sample presented together with reset must be discarded
        en = 1'b1; val = 32'd1000;
        @(posedge clk);
        #1;
        rst = 1'b0; en = 1'b0;
        check("rst_en_w3_sol", w3_sol, 0);
        check("rst_en_w1_primed", {31'd0, w1_primed}, 0);

        // Increase, primed must rise exactly after the 3rd accept
        mode = MODE_INC;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, stream[i]);
            check($sformatf("inc_w3_primed_%0d", i), {31'd0, w3_primed}, (i >= 2) ? 1 : 0);
        end
        en = 1'b0;
        check("inc_w1_sol", w1_sol, 7);
        check("inc_w1_sat", {31'd0, w1_sat}, 0);
        check("inc_w3_sol", w3_sol, 5);
        step(1'b0, 32'd5);
        check("inc_hold_w3_sol", w3_sol, 5);

        // Decrease
        do_reset();
        mode = MODE_DEC;
        run_stream();
        check("dec_w3_sol", w3_sol, 1);
        check("dec_w1_sol", w1_sol, 2);

        // Equal
        do_reset();
        mode = MODE_EQ;
        run_stream();
        check("eq_w3_sol", w3_sol, 1);
        check("eq_w1_sol", w1_sol, 0);

        // Reserved mode never matches
        do_reset();
        mode = MODE_RSVD;
        run_stream();
        check("rsvd_w3_sol", w3_sol, 0);
        check("rsvd_w1_sol", w1_sol, 0);
        check("rsvd_w3_primed", {31'd0, w3_primed}, 1);

        // Random enable gaps with junk on value must not change the result
        do_reset();
        mode = MODE_INC;
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 2)) step(1'b0, $urandom);
            step(1'b1, stream[i]);
        end
        en = 1'b0;
        check("gap_w3_sol", w3_sol, 5);
        check("gap_w1_sol", w1_sol, 7);

        // Mode switch mid-stream keeps the accumulated count
        do_reset();
        mode = MODE_INC;
        for (int i = 0; i < 5; i++) step(1'b1, stream[i]);
        check("mix_w3_mid", w3_sol, 1);
        check("mix_w1_mid", w1_sol, 3);
        mode = MODE_DEC;
        for (int i = 5; i < 10; i++) step(1'b1, stream[i]);
        en = 1'b0;
        check("mix_w3_sol", w3_sol, 2);
        check("mix_w1_sol", w1_sol, 4);

        // Reset after 5 accepts, then refill without counting
        do_reset();
        mode = MODE_INC;
        for (int i = 0; i < 5; i++) step(1'b1, stream[i]);
        check("mid_pre_sol", w3_sol, 1);
        do_reset();
        check("mid_post_sol", w3_sol, 0);
        check("mid_post_primed", {31'd0, w3_primed}, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, stream[i]);
            check($sformatf("mid_refill_sol_%0d", i), w3_sol, 0);
        end
        check("mid_refill_primed", {31'd0, w3_primed}, 1);
        step(1'b1, stream[3]);
        en = 1'b0;
        check("mid_first_cmp_sol", w3_sol, 1);

        // Saturation on the 3-bit counter: matches on accepts 2..12
        for (int k = 1; k <= 12; k++) begin
            s_en  = 1'b1;
            s_val = k;
            @(posedge clk);
            #1;
            check($sformatf("sat_sol_%0d", k), {29'd0, s_sol}, (k - 1 > 7) ? 7 : k - 1);
            check($sformatf("sat_flag_%0d", k), {31'd0, s_sat}, (k - 1 >= 8) ? 1 : 0);
        end
        s_en = 1'b0;
        @(posedge clk);
        #1;
        check("sat_hold_sol", {29'd0, s_sol}, 7);
        check("sat_hold_flag", {31'd0, s_sat}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
